// File: rtl/button_event_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_event_arbiter_pkg : shared event codes and default constants  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package button_event_arbiter_pkg;

   localparam logic EVT_SHORT = 1'b0;
   localparam logic EVT_LONG  = 1'b1;

   localparam int unsigned DEF_TICK_DIV   = 250000;
   localparam int unsigned DEF_DEPTH      = 4;
   localparam int unsigned DEF_LONG_TICKS = 200;

   // (base + k) mod n for base < n and k < n, without a divider
   function automatic int unsigned rr_index(input int unsigned base,
                                            input int unsigned k,
                                            input int unsigned n);
      int unsigned s;
      s = base + k;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_arbiter_pb_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_event_arbiter_pb_filter : hysteresis filter, hold counter and |
// | short/long press pulses for one pushbutton.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module button_event_arbiter_pb_filter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned LONG_TICKS = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic pb,
   output logic level,
   output logic long_post,
   output logic short_post
);

   localparam int unsigned HW = $clog2(LONG_TICKS + 1);
   localparam logic [HW-1:0] C_LONG    = HW'(LONG_TICKS);
   localparam logic [HW-1:0] C_LONG_M1 = HW'(LONG_TICKS - 1);

   logic [DEPTH-1:0] r_sr;
   logic             r_level;
   logic [HW-1:0]    r_hold;
   logic             r_long_post;
   logic             r_short_post;
   logic [DEPTH-1:0] w_sr_next;
   logic             w_level_next;

   assign w_sr_next    = {r_sr[DEPTH-2:0], pb};
   assign w_level_next = (&w_sr_next) ? 1'b1 : ((~|w_sr_next) ? 1'b0 : r_level);

   // Hold only counts ticks where the level stays high, so a press that
   // falls on the tick that would have reached LONG_TICKS is still short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr         <= '0;
         r_level      <= 1'b0;
         r_hold       <= '0;
         r_long_post  <= 1'b0;
         r_short_post <= 1'b0;
      end else begin
         r_long_post  <= 1'b0;
         r_short_post <= 1'b0;
         if (tick) begin
            r_sr    <= w_sr_next;
            r_level <= w_level_next;
            if (!r_level && w_level_next)
               r_hold <= '0;
            else if (r_level && w_level_next && (r_hold < C_LONG))
               r_hold <= r_hold + 1'b1;
            r_long_post  <= r_level && w_level_next && (r_hold == C_LONG_M1);
            r_short_post <= r_level && !w_level_next && (r_hold < C_LONG);
         end
      end
   end

   assign level      = r_level;
   assign long_post  = r_long_post;
   assign short_post = r_short_post;

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_event_arbiter : per-button filters, pending slots and a       |
// | round-robin valid/ready event port.  Rev 1.0                         |
// +----------------------------------------------------------------------+
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int unsigned N_BTN      = 4,
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned LONG_TICKS = DEF_LONG_TICKS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_BTN-1:0]         pb,
   output logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     evt_long,
   output logic                     overrun
);

   localparam int unsigned IW = $clog2(N_BTN);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] C_LAST_BTN   = IW'(N_BTN - 1);

   logic [PW-1:0]    r_presc;
   logic             w_tick;
   logic [N_BTN-1:0] w_long_post, w_short_post, w_post, w_grant_oh;
   logic [N_BTN-1:0] r_pend, r_ptype;
   logic [IW-1:0]    r_rr, w_grant_idx, w_scan, w_rr_next, r_id;
   logic             w_any_pend, w_load;
   logic             r_valid, r_long, r_overrun;

   assign w_tick = (r_presc == C_PRESC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      button_event_arbiter_pb_filter #(
         .DEPTH      (DEPTH),
         .LONG_TICKS (LONG_TICKS)
      ) u_filter (
         .clk        (clk),
         .rst        (rst),
         .tick       (w_tick),
         .pb         (pb[i]),
         .level      (btn_level[i]),
         .long_post  (w_long_post[i]),
         .short_post (w_short_post[i])
      );
   end

   assign w_post = w_long_post | w_short_post;

   // First pending slot at or after the round-robin pointer.
   always_comb begin
      w_any_pend  = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int k = 0; k < int'(N_BTN); k++) begin
         w_scan = IW'(rr_index(32'(r_rr), k, N_BTN));
         if (!w_any_pend && r_pend[w_scan]) begin
            w_any_pend  = 1'b1;
            w_grant_idx = w_scan;
         end
      end
   end

   assign w_load    = (!r_valid || evt_ready) && w_any_pend;
   assign w_rr_next = (w_grant_idx == C_LAST_BTN) ? '0 : w_grant_idx + 1'b1;

   always_comb begin
      w_grant_oh = '0;
      if (w_load) w_grant_oh[w_grant_idx] = 1'b1;
   end

   // A post in the grant cycle wins over the grant's clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend    <= '0;
         r_ptype   <= '0;
         r_overrun <= 1'b0;
      end else begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            if (w_post[i]) begin
               r_pend[i]  <= 1'b1;
               r_ptype[i] <= w_long_post[i] ? EVT_LONG : EVT_SHORT;
            end else if (w_grant_oh[i]) begin
               r_pend[i]  <= 1'b0;
            end
         end
         r_overrun <= |(w_post & r_pend & ~w_grant_oh);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_id    <= '0;
         r_long  <= EVT_SHORT;
         r_rr    <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_id    <= w_grant_idx;
         r_long  <= r_ptype[w_grant_idx];
         r_rr    <= w_rr_next;
      end else if (evt_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign evt_valid = r_valid;
   assign evt_id    = r_id;
   assign evt_long  = r_long;
   assign overrun   = r_overrun;

endmodule
`default_nettype wire
